// File: rtl/mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter and sequencer for a wide flow-control multiplexer.
// N valid/ready requesters share one mux. The current winner drives the mux
// select, and the winning word is captured into a one-entry output register
// that has its own valid/ready handshake.
//
// Optional feature macro: MUX_ARB_LOCK_EN
//   When defined, this adds input req_lock. A requester that is granted with
//   req_lock high keeps exclusive ownership until it sends a beat with
//   req_lock low.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   req_valid  in   N          per-requester valid
//   req_data   in   N*DATA_W   packed request words, requester i at [i*DATA_W +: DATA_W]
//   req_lock   in   N          (MUX_ARB_LOCK_EN only) hold ownership after this beat
//   req_ready  out  N          one-hot accept (combinational)
//   sel        out  SEL_W      mux select = winner index, 0 when nothing is granted
//   out_valid  out  1          output register holds a word
//   out_data   out  DATA_W     registered selected word
//   out_src    out  SEL_W      index of the requester that supplied out_data
//   out_ready  in   1          downstream accept
// ----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N      = 32,
    parameter int SEL_W  = 5,
    parameter int DATA_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N*DATA_W-1:0] req_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N-1:0]        req_lock,
`endif
    output logic [N-1:0]        req_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    out_src,
    input  logic                out_ready
);

    localparam logic [SEL_W-1:0] PTR_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_src;
    logic [SEL_W-1:0]  r_ptr;
`ifdef MUX_ARB_LOCK_EN
    logic              r_lock;
    logic [SEL_W-1:0]  r_lock_idx;
`endif

    logic              w_can_load;
    logic [N-1:0]      w_eligible;
    logic              w_any;
    logic [SEL_W-1:0]  w_win;
    logic [SEL_W-1:0]  w_scan_idx;
    logic              w_grant;

    // A new word may load when the register is empty or is draining this cycle.
    assign w_can_load = !r_out_valid || out_ready;

    // Requesters allowed to compete this cycle.
    always_comb begin
        w_eligible = '0;
`ifdef MUX_ARB_LOCK_EN
        // While a lock is held, only the owner may win, even if it is idle.
        if (r_lock) begin
            w_eligible[r_lock_idx] = req_valid[r_lock_idx];
        end else begin
            w_eligible = req_valid;
        end
`else
        w_eligible = req_valid;
`endif
    end

    // Rotating priority scan. The loop runs from the farthest offset down to
    // the nearest one, so the requester closest to r_ptr is assigned last and wins.
    always_comb begin
        w_any      = 1'b0;
        w_win      = '0;
        w_scan_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            w_scan_idx = r_ptr + j[SEL_W-1:0];
            if (w_eligible[w_scan_idx]) begin
                w_any = 1'b1;
                w_win = w_scan_idx;
            end else begin
                w_any = w_any;
                w_win = w_win;
            end
        end
    end

    // Reset gates the grant so that req_ready and sel drop to zero as soon as
    // rst is asserted.
    assign w_grant = !rst && w_can_load && w_any;

    // One-hot accept and mux select derived from the winner.
    always_comb begin
        req_ready = '0;
        sel       = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
            sel              = w_win;
        end else begin
            req_ready = '0;
            sel       = '0;
        end
    end

    // Output register, rotating pointer and lock state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
`endif
        end else begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_data[w_win*DATA_W +: DATA_W];
                r_out_src   <= w_win;
`ifdef MUX_ARB_LOCK_EN
                // Locked beats freeze the pointer. The releasing beat moves it
                // past the owner.
                if (req_lock[w_win]) begin
                    r_lock     <= 1'b1;
                    r_lock_idx <= w_win;
                end else begin
                    r_lock     <= 1'b0;
                    r_ptr      <= w_win + PTR_ONE;
                end
`else
                r_ptr       <= w_win + PTR_ONE;
`endif
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    localparam int N      = 32;
    localparam int SEL_W  = 5;
    localparam int DATA_W = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*DATA_W-1:0] req_data;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]        req_lock;
`endif
    logic [N-1:0]        req_ready;
    logic [SEL_W-1:0]    sel;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [SEL_W-1:0]    out_src;
    logic                out_ready;

    mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef MUX_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Requester i presents word base+i.
    task automatic set_data(input logic [DATA_W-1:0] base);
        for (int i = 0; i < N; i++) req_data[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a grant to idx in the current cycle, and queue the word it must produce.
    task automatic expect_grant(input int idx, input logic [DATA_W-1:0] base);
        exp_t e;
        #1;
        check("req_ready", req_ready, 32'd1 << idx);
        check("sel", 32'(sel), 32'(idx));
        e.src  = SEL_W'(idx);
        e.data = base + DATA_W'(idx);
        sb_q.push_back(e);
    endtask

    task automatic expect_idle();
        #1;
        check("req_ready_idle", req_ready, 32'd0);
        check("sel_idle", 32'(sel), 32'd0);
    endtask

    // Monitor: on every accepted output word, compare against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got src=%0d data=0x%0h expected none", out_src, out_data);
            end else begin
                e = sb_q.pop_front();
                check("out_src", 32'(out_src), 32'(e.src));
                check("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        set_data(20'h00000);
`ifdef MUX_ARB_LOCK_EN
        req_lock  = '0;
`endif
        // Reset held with every requester valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);

        // Release: the first grant goes to 0, then the rotation continues through the wrap.
        rst = 1'b0;
        expect_grant(0, 20'h00000);
        for (int k = 1; k <= 32; k++) begin
            step();
            expect_grant(k % 32, 20'h00000);
        end
        step();
        req_valid = '0;
        expect_idle();

        // Sparse: granting 4 alone leaves ptr=5, then scan over {2,4,31}.
        step();
        req_valid = 32'h0000_0010;
        set_data(20'h00100);
        expect_grant(4, 20'h00100);
        step();
        req_valid = 32'h8000_0014;
        expect_grant(31, 20'h00100);
        step(); expect_grant(2, 20'h00100);
        step(); expect_grant(4, 20'h00100);
        step(); expect_grant(31, 20'h00100);
        step();
        req_valid = '0;
        expect_idle();

        // Backpressure: ptr is 0 after the grant to 31.
        step();
        req_valid = '1;
        set_data(20'h00200);
        expect_grant(0, 20'h00200);
        for (int c = 0; c < 3; c++) begin
            step();
            out_ready = 1'b0;
            expect_idle();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h00200);
        end
        step();
        out_ready = 1'b1;
        expect_grant(1, 20'h00200);
        step();
        expect_grant(2, 20'h00200);
        check("no_bubble", 32'(out_valid), 32'd1);
        step();
        req_valid = 32'h0000_0080;
        expect_grant(7, 20'h00200);

        // Mid-operation reset while word 7 is held.
        step();
        req_valid = '0;
        out_ready = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_src", 32'(out_src), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        check("async_out_src", 32'(out_src), 32'd0);
        check("async_req_ready", req_ready, 32'd0);
        check("discard_pending", 32'(sb_q.size()), 32'd1);
        sb_q.delete();

        // After release, ptr must be 0: requests {5,9} give 5 (ptr=8 would give 9).
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 32'h0000_0220;
        set_data(20'h00300);
        expect_grant(5, 20'h00300);

`ifdef MUX_ARB_LOCK_EN
        // Lock: 3 holds ownership for three beats while 4 waits.
        step();
        req_valid = 32'h0000_0018;
        req_lock  = 32'h0000_0008;
        set_data(20'h00400);
        expect_grant(3, 20'h00400);
        step(); expect_grant(3, 20'h00400);
        step();
        req_lock = '0;
        expect_grant(3, 20'h00400);
        step(); expect_grant(4, 20'h00400);
`endif

        // Drain the remaining words with a bounded wait.
        step();
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 32-way, 20-bit flow-control multiplexer. It shares the mux between 32 valid/ready requesters and drives the mux select from the current winner. The selected word is captured into a one-entry output register with its own valid/ready handshake. The block sits between the requesting units and the downstream consumer of the mux output.

## Interface
Parameters:
- N, 32, number of requesters (power of two)
- SEL_W, 5, select/index width, log2(N)
- DATA_W, 20, data word width

Ports:
- clk, input, 1, rising-edge clock; the block's only clock
- rst, input, 1, asynchronous, active-high reset
- req_valid, input, N, per-requester valid
- req_data, input, N*DATA_W, packed request words; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready, output, N, one-hot accept; at most one bit high per cycle
- sel, output, SEL_W, combinational mux select; equals the current winner index, or 0 when no request is granted
- out_valid, output, 1, output register holds a word
- out_data, output, DATA_W, registered selected word
- out_src, output, SEL_W, index of the requester that supplied out_data
- out_ready, input, 1, downstream accept

## Operation
- State: out_valid (EMPTY/FULL), a rotating priority pointer ptr[SEL_W-1:0], and, under the macro, a lock flag plus lock_idx.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, sel=0, req_ready=0, lock=0.
- Winner: the first i with req_valid[i]=1, scanning ptr, ptr+1, …, ptr+N-1 modulo N.
- can_load = !out_valid || out_ready.
- When can_load is high and any req_valid is high:
  - req_ready[winner]=1.
  - Next edge: out_data ← req_data[winner], out_src ← winner, out_valid ← 1, ptr ← winner+1 mod N.
- Pointer wrap: winner 31 sets ptr to 0.
- When can_load is high and no request is valid: req_ready=0; out_valid clears if it was draining.
- When out_valid=1 and out_ready=0: req_ready=0, and the output register and ptr hold.
- Simultaneous drain and load in one cycle: the new word replaces the old one, out_valid stays 1, and no bubble is inserted.
- Requesters not granted keep their word; the arbiter never drops or duplicates a request.
- sel is driven from the winner whenever can_load is high, so the external mux output matches req_data[winner] in the same cycle.

## Timing
- Latency: 1 cycle from the req_valid&req_ready handshake to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready=1.
- req_ready, sel: combinational from req_valid, ptr, out_valid, out_ready and lock. They do not depend on req_data.
- Fairness: with all N requesters continuously valid and out_ready=1, each is granted exactly once every N cycles.
- Reset asserted mid-operation: a held word is discarded, ptr returns to 0, and all outputs take their reset values immediately (asynchronously).
- Reset deassertion: the first grant is possible on the first edge after rst falls.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - Adds input req_lock[N-1:0].
  - A grant accepted with req_lock[winner]=1 sets lock=1 and lock_idx=winner.
  - While locked, only lock_idx can be granted. Other requesters see req_ready=0 even when lock_idx is not valid, and ptr does not advance.
  - A beat accepted from lock_idx with req_lock=0 clears lock and sets ptr=lock_idx+1.
- MUX_ARB_LOCK_EN undefined:
  - No req_lock port and no lock state.
  - Plain round-robin as described above.

## Test plan
- Reset: hold rst with all req_valid=1. Expect out_valid=0, req_ready=0, sel=0. After release, the first grant is index 0 and out_src=0 one cycle later.
- Rotation: all 32 requesters valid, requester i sending data = i, out_ready=1. Expect out_data sequence 0,1,…,31,0 and ptr wrap 31→0.
- Sparse requests: only requesters 2, 4 and 31 valid, ptr=5. Expect grants in order 31, 2, 4, 31, with sel matching each grant in its cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1. Expect req_ready=0 and out_data stable; on the cycle out_ready=1, the next word loads with no bubble.
- Mid-operation reset: assert rst while out_valid=1, out_src=7. Expect out_valid=0 and out_data=0 immediately, and ptr=0 after release.
- Lock (MUX_ARB_LOCK_EN): requester 3 sends 3 beats with req_lock=1,1,0 while requester 4 is also valid. Expect 3 consecutive grants to 3, then a grant to 4.
